seq_chunk_adder: RTL and testbench

SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

---
 rtl/seq_chunk_adder.sv | 133 +++++++++++++
 tb/tb_seq_chunk_adder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per clock, LSB chunk first.
// Define SEQ_ADDER_OVF_EN to add the signed-overflow output ovf.
module seq_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SEQ_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [IDX_W-1:0] r_idx;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_chunk_total;
  logic             w_chunk_cout;
  logic             w_last;

  // Chunk select uses constant part-selects so the mux stays lint-clean for any NCHUNK.
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_chunk = r_a[k*CHUNK +: CHUNK];
        w_b_chunk = r_b[k*CHUNK +: CHUNK];
      end
    end
  end

  assign w_chunk_total = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
  assign w_chunk_cout  = w_chunk_total[CHUNK];
  assign w_last        = (r_idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            // Subtract is a + ~b + 1, with borrow-in folded into the inverted carry.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= cin ^ sub;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int k = 0; k < NCHUNK; k++) begin
            if (r_idx == IDX_W'(k)) begin
              r_sum[k*CHUNK +: CHUNK] <= w_chunk_total[CHUNK-1:0];
            end
          end
          r_carry <= w_chunk_cout;
          if (w_last) begin
            r_cout  <= w_chunk_cout;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_ADDER_OVF_EN
  logic r_ovf;
  logic w_msb_carry_in;

  // Carry into the MSB recovered from the sum bit: s = a ^ b ^ c.
  assign w_msb_carry_in = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_chunk_total[CHUNK-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_ovf <= w_msb_carry_in ^ w_chunk_cout;
    end
  end

  assign ovf = r_ovf;
`endif

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed and random checks of seq_chunk_adder at 8/4, 16/16 and 16/1 configurations.
// Overflow checks are compiled in only when SEQ_ADDER_OVF_EN is defined.
module tb_seq_chunk_adder;

  logic clk;
  logic rst;

  // WIDTH=8, CHUNK=4 instance
  logic       m_in_valid, m_in_ready, m_cin, m_sub, m_out_valid, m_out_ready, m_cout, m_busy;
  logic [7:0] m_a, m_b, m_sum;
`ifdef SEQ_ADDER_OVF_EN
  logic       m_ovf;
`endif

  // WIDTH=16, CHUNK=16 instance
  logic        p_in_valid, p_in_ready, p_cin, p_sub, p_out_valid, p_out_ready, p_cout, p_busy;
  logic [15:0] p_a, p_b, p_sum;
`ifdef SEQ_ADDER_OVF_EN
  logic        p_ovf;
`endif

  // WIDTH=16, CHUNK=1 instance
  logic        s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_out_ready, s_cout, s_busy;
  logic [15:0] s_a, s_b, s_sum;
`ifdef SEQ_ADDER_OVF_EN
  logic        s_ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  seq_chunk_adder #(.WIDTH(8), .CHUNK(4)) u_main (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .cin(m_cin), .sub(m_sub),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .sum(m_sum), .cout(m_cout), .busy(m_busy)
`ifdef SEQ_ADDER_OVF_EN
    , .ovf(m_ovf)
`endif
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_par (
    .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .a(p_a), .b(p_b), .cin(p_cin), .sub(p_sub),
    .out_valid(p_out_valid), .out_ready(p_out_ready),
    .sum(p_sum), .cout(p_cout), .busy(p_busy)
`ifdef SEQ_ADDER_OVF_EN
    , .ovf(p_ovf)
`endif
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_ser (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .sum(s_sum), .cout(s_cout), .busy(s_busy)
`ifdef SEQ_ADDER_OVF_EN
    , .ovf(s_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called 1 time unit after a rising edge with the 8/4 instance idle; returns edges from accept to out_valid.
  task automatic run_main(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                          input logic tsub, output int lat);
    m_a = ta; m_b = tb; m_cin = tcin; m_sub = tsub; m_in_valid = 1'b1;
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    lat = 0;
    while (!m_out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("[TB] op a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d latency=%0d",
             ta, tb, tcin, tsub, m_sum, m_cout, lat);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    m_in_valid = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0; m_out_ready = 1'b1;
    p_in_valid = 1'b0; p_a = '0; p_b = '0; p_cin = 1'b0; p_sub = 1'b0; p_out_ready = 1'b1;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0; s_out_ready = 1'b1;
    #12;
    n_tests++;
    if ({m_in_ready, m_out_valid, m_busy, m_cout, m_sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: ready/valid/busy/cout/sum got %b%b%b%b/%h want 1000/00",
               m_in_ready, m_out_valid, m_busy, m_cout, m_sum);
    end
`ifdef SEQ_ADDER_OVF_EN
    n_tests++;
    if (m_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b want 0", m_ovf);
    end
`endif
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    $display("[TB] reset released");
  endtask

  task automatic test_add;
    int lat;
    m_out_ready = 1'b1;
    run_main(8'h3C, 8'h0F, 1'b0, 1'b0, lat);
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d want 2", lat); end
    n_tests++;
    if ({m_cout, m_sum} !== {1'b0, 8'h4B}) begin
      n_fail++; $display("FAIL add_3c_0f: got cout=%b sum=%h want cout=0 sum=4b", m_cout, m_sum);
    end
    n_tests++;
    if (m_in_ready !== 1'b0 || m_busy !== 1'b1) begin
      n_fail++; $display("FAIL done_flags: got in_ready=%b busy=%b want 0 1", m_in_ready, m_busy);
    end
    @(posedge clk); #1;
    n_tests++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL handshake_idle: got in_ready=%b out_valid=%b want 1 0", m_in_ready, m_out_valid);
    end

    run_main(8'hFF, 8'h01, 1'b0, 1'b0, lat);
    n_tests++;
    if ({m_cout, m_sum} !== {1'b1, 8'h00} || lat !== 2) begin
      n_fail++; $display("FAIL add_ff_01: got cout=%b sum=%h lat=%0d want cout=1 sum=00 lat=2", m_cout, m_sum, lat);
    end
`ifdef SEQ_ADDER_OVF_EN
    n_tests++;
    if (m_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_ff_01: got %b want 0", m_ovf); end
`endif
    @(posedge clk); #1;

    run_main(8'h7F, 8'h01, 1'b0, 1'b0, lat);
    n_tests++;
    if ({m_cout, m_sum} !== {1'b0, 8'h80} || lat !== 2) begin
      n_fail++; $display("FAIL add_7f_01: got cout=%b sum=%h lat=%0d want cout=0 sum=80 lat=2", m_cout, m_sum, lat);
    end
`ifdef SEQ_ADDER_OVF_EN
    n_tests++;
    if (m_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_7f_01: got %b want 1", m_ovf); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_sub;
    int lat;
    m_out_ready = 1'b1;
    run_main(8'h05, 8'h07, 1'b0, 1'b1, lat);
    n_tests++;
    if ({m_cout, m_sum} !== {1'b0, 8'hFE} || lat !== 2) begin
      n_fail++; $display("FAIL sub_05_07: got cout=%b sum=%h lat=%0d want cout=0 sum=fe lat=2", m_cout, m_sum, lat);
    end
    @(posedge clk); #1;
    run_main(8'h07, 8'h05, 1'b1, 1'b1, lat);
    n_tests++;
    if ({m_cout, m_sum} !== {1'b1, 8'h01} || lat !== 2) begin
      n_fail++; $display("FAIL sub_07_05_b1: got cout=%b sum=%h lat=%0d want cout=1 sum=01 lat=2", m_cout, m_sum, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hold;
    int lat;
    m_out_ready = 1'b0;
    run_main(8'h12, 8'h34, 1'b1, 1'b0, lat);
    n_tests++;
    if ({m_cout, m_sum} !== {1'b0, 8'h47} || lat !== 2) begin
      n_fail++; $display("FAIL hold_result: got cout=%b sum=%h lat=%0d want cout=0 sum=47 lat=2", m_cout, m_sum, lat);
    end
    for (int i = 0; i < 5; i++) begin
      m_in_valid = (i % 2 == 0);
      m_a = 8'hA0 + 8'(i); m_b = 8'h5A; m_cin = 1'b1; m_sub = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if ({m_out_valid, m_in_ready, m_cout, m_sum} !== {1'b1, 1'b0, 1'b0, 8'h47}) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: got valid=%b ready=%b cout=%b sum=%h want 1 0 0 47",
                 i, m_out_valid, m_in_ready, m_cout, m_sum);
      end
    end
    $display("[TB] held DONE for 5 cycles with out_ready=0");
    // in_valid stays high through the handshake edge: it must not start a new op.
    m_in_valid = 1'b1;
    m_out_ready = 1'b1;
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    n_tests++;
    if ({m_in_ready, m_out_valid, m_busy, m_sum} !== {1'b1, 1'b0, 1'b0, 8'h47}) begin
      n_fail++;
      $display("FAIL hold_release: got ready=%b valid=%b busy=%b sum=%h want 1 0 0 47",
               m_in_ready, m_out_valid, m_busy, m_sum);
    end
  endtask

  task automatic test_reset_abort;
    int lat;
    logic saw_valid;
    m_out_ready = 1'b1;
    m_a = 8'h99; m_b = 8'h99; m_cin = 1'b1; m_sub = 1'b0; m_in_valid = 1'b1;
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({m_in_ready, m_out_valid, m_busy, m_cout, m_sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL async_reset: ready/valid/busy/cout/sum got %b%b%b%b/%h want 1000/00",
               m_in_ready, m_out_valid, m_busy, m_cout, m_sum);
    end
    saw_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (m_out_valid) saw_valid = 1'b1;
    end
    n_tests++;
    if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_valid: got pulse want none"); end
    $display("[TB] reset asserted mid-run, releasing");
    @(negedge clk) rst = 1'b0;
    run_main(8'h21, 8'h10, 1'b0, 1'b1, lat);
    n_tests++;
    if ({m_cout, m_sum} !== {1'b1, 8'h11} || lat !== 2) begin
      n_fail++; $display("FAIL after_abort: got cout=%b sum=%h lat=%0d want cout=1 sum=11 lat=2", m_cout, m_sum, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wide_w16_c16;
    int lat, errs;
    logic [15:0] ea, eb, es;
    logic ec, ecin, esub;
    errs = 0;
    for (int n = 0; n < 1000; n++) begin
      ea = 16'($urandom); eb = 16'($urandom); ecin = 1'($urandom); esub = 1'($urandom);
      if (!esub) {ec, es} = {1'b0, ea} + {1'b0, eb} + {16'd0, ecin};
      else begin
        es = ea - eb - {15'd0, ecin};
        ec = (int'(ea) >= int'(eb) + int'(ecin));
      end
      p_a = ea; p_b = eb; p_cin = ecin; p_sub = esub; p_in_valid = 1'b1;
      @(posedge clk); #1;
      p_in_valid = 1'b0;
      lat = 0;
      while (!p_out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      n_tests++;
      if ({p_cout, p_sum} !== {ec, es} || lat !== 1) begin
        n_fail++; errs++;
        $display("FAIL w16c16[%0d]: a=%h b=%h cin=%0d sub=%0d got cout=%b sum=%h lat=%0d want cout=%b sum=%h lat=1",
                 n, ea, eb, ecin, esub, p_cout, p_sum, lat, ec, es);
      end
      @(posedge clk); #1;
    end
    $display("[TB] W16/C16 random: 1000 ops, %0d errors", errs);
  endtask

  task automatic test_wide_w16_c1;
    int lat, errs;
    logic [15:0] ea, eb, es;
    logic ec, ecin, esub;
    errs = 0;
    for (int n = 0; n < 1000; n++) begin
      ea = 16'($urandom); eb = 16'($urandom); ecin = 1'($urandom); esub = 1'($urandom);
      if (!esub) {ec, es} = {1'b0, ea} + {1'b0, eb} + {16'd0, ecin};
      else begin
        es = ea - eb - {15'd0, ecin};
        ec = (int'(ea) >= int'(eb) + int'(ecin));
      end
      s_a = ea; s_b = eb; s_cin = ecin; s_sub = esub; s_in_valid = 1'b1;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      lat = 0;
      while (!s_out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      n_tests++;
      if ({s_cout, s_sum} !== {ec, es} || lat !== 16) begin
        n_fail++; errs++;
        $display("FAIL w16c1[%0d]: a=%h b=%h cin=%0d sub=%0d got cout=%b sum=%h lat=%0d want cout=%b sum=%h lat=16",
                 n, ea, eb, ecin, esub, s_cout, s_sum, lat, ec, es);
      end
      @(posedge clk); #1;
    end
    $display("[TB] W16/C1 random: 1000 ops, %0d errors", errs);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_hold();
    test_reset_abort();
    test_wide_w16_c16();
    test_wide_w16_c1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
